ufm_stream_reader: RTL and testbench
====================================

Name: ufm_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the on-chip user flash data port.
- On a start command it fetches a run of 32-bit flash words using bursts, buffers them in a word FIFO, and serializes them into a byte stream with a valid/ready handshake.
- The byte stream typically feeds the UART transmitter.
- Burst issue is credit-gated, so the FIFO can never overflow.

Parameters:
- BURST_LEN, 8, maximum words per burst; legal range 1..15.
- FIFO_DEPTH, 16, word FIFO depth; power of two, must be >= BURST_LEN.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- start_addr  in  15  first flash word address, sampled on an accepted start.
- word_count  in  16  number of words to fetch, sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte has been accepted downstream.
- avmm_data_addr  out  15  burst start word address.
- avmm_data_read  out  1  read request.
- avmm_data_burstcount  out  4  words in the current burst.
- avmm_data_readdata  in  32  returned word.
- avmm_data_waitrequest  in  1  slave stall.
- avmm_data_readdatavalid  in  1  return-beat qualifier.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.

Behaviour:
- Reset values:
  - busy, done, avmm_data_read, out_valid = 0.
  - avmm_data_addr, avmm_data_burstcount, out_data = 0.
  - FIFO empty; outstanding count = 0; state IDLE.
- Reset mid-operation aborts everything immediately and returns the block to IDLE. No done pulse is generated.
- Internal counters:
  - remaining (16 bit): words not yet requested.
  - outstanding (5 bit): words requested but not yet returned.
  - credit = FIFO_DEPTH - fifo_level - outstanding.
- FSM states and transitions:
  - IDLE: a start with word_count != 0 latches the address and count, sets busy, and moves to ARB. A start with word_count = 0 moves to FINISH, with no bus activity.
  - ARB: compute n = min(BURST_LEN, remaining). If credit >= n, drive avmm_data_addr = current address, avmm_data_burstcount = n, avmm_data_read = 1, and move to ISSUE. Otherwise stay in ARB.
  - ISSUE: hold read, address and burstcount stable while avmm_data_waitrequest = 1. On the first cycle with waitrequest = 0 the command is accepted, and in that cycle:
    - deassert read;
    - outstanding += n; remaining -= n;
    - address += n, modulo 2^15 (address wraps 0x7FFF -> 0x0000);
    - next state is ARB if remaining != 0, else DRAIN.
  - DRAIN: wait until outstanding = 0, the FIFO is empty, and the serializer is idle; then move to FINISH.
  - FINISH: pulse done for one cycle, clear busy, return to IDLE.
- Multiple bursts may be in flight; a new burst may issue before the previous one has returned.
- Return path:
  - Each readdatavalid beat writes readdata into the FIFO and decrements outstanding.
  - Beats arriving with outstanding = 0 (stale traffic after a reset) are discarded.
- Serializer:
  - Loads a word from the FIFO when idle, or in the same cycle the last byte of the current word is accepted.
  - Emits bytes little-endian: readdata[7:0] first, [31:24] last.
  - A byte is transferred when out_valid && out_ready.
  - out_data is held stable while out_valid=1 && out_ready=0.
- Latency: a beat with readdatavalid in cycle T, serializer idle and FIFO empty, gives out_valid=1 in cycle T+2.
- Throughput: 1 byte/cycle sustained while out_ready=1.
- Simultaneous FIFO write and read in the same cycle is legal, including when the FIFO is full, because credit gating guarantees no overflow.
- A start pulse while busy=1 is ignored and has no effect on the run in progress.

Test Plan:
- start_addr=0x0010, word_count=3, slave returns 0x44332211, 0x88776655, 0xCCBBAA99, out_ready=1 -> one burst (addr 0x0010, burstcount 3); bytes 11 22 33 44 55 66 77 88 99 AA BB CC; done pulses exactly once after the 12th byte.
- word_count=20, BURST_LEN=8, slave waitrequest=1 for 3 cycles per command -> bursts at addr, addr+8, addr+16 with burstcount 8, 8, 4; read/addr/burstcount held stable through each stall; 80 bytes out.
- word_count=40 with out_ready=0 held for 200 cycles -> read stops once credit < 8; fifo_level + outstanding never exceeds 16; after out_ready=1, all 160 bytes arrive in order.
- start_addr=0x7FFC, word_count=8 -> bursts issue at 0x7FFC (burstcount 8), then the internal address is 0x0004, with no error.
- word_count=0 -> done one cycle after FINISH entry; avmm_data_read never asserted; start pulse while busy ignored.
- reset asserted mid-burst with 5 words outstanding, then 5 stale readdatavalid beats, then new start word_count=1 -> stale beats discarded; exactly 4 bytes of the new word emitted.

Source files
------------

// File: rtl/ufm_stream_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ufm_stream_reader
//
// Avalon-MM burst read master for the on-chip user flash data port. A start
// command fetches word_count 32-bit words beginning at start_addr. Reads go
// out in bursts of at most BURST_LEN words. Returned words are buffered in
// a FIFO_DEPTH-word FIFO. They leave as a little-endian byte stream with a
// valid/ready handshake.
//
// A burst is only issued when the FIFO has room for every word that has
// been requested and not yet consumed:
//     credit = FIFO_DEPTH - fifo_level - outstanding
// As a result, return beats never overflow the FIFO.
//
// Ports:
//   clock, reset             system clock; synchronous active-high reset
//   start                    one-cycle command pulse, ignored while busy
//   start_addr, word_count   run parameters, sampled on an accepted start
//   busy, done               run in progress / one-cycle completion pulse
//   avmm_data_*              Avalon-MM burst read master to the flash
//   out_data, out_valid,     byte stream out, transfer on
//   out_ready                out_valid && out_ready
// ---------------------------------------------------------------------------
module ufm_stream_reader #(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] start_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [14:0] avmm_data_addr,
    output logic        avmm_data_read,
    output logic [3:0]  avmm_data_burstcount,
    input  logic [31:0] avmm_data_readdata,
    input  logic        avmm_data_waitrequest,
    input  logic        avmm_data_readdatavalid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic [14:0]     addr_r;
    logic [15:0]     remaining_r;
    logic [LW-1:0]   outstanding_r;

    logic [31:0]     fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   fifo_level_r;

    logic [23:0]     ser_shift_r;
    logic [1:0]      ser_left_r;

    logic            start_acc_s;
    logic            grant_s;
    logic            accept_s;
    logic [3:0]      burst_n_s;
    logic [LW-1:0]   credit_s;
    logic            beat_s;
    logic            last_taken_s;
    logic            ser_load_s;
    logic [31:0]     fifo_head_s;

    // Never negative, because level + outstanding never exceeds FIFO_DEPTH.
    assign credit_s = LW'(FIFO_DEPTH) - fifo_level_r - outstanding_r;

    // Beats that arrive with nothing outstanding are left over from before a
    // reset. They are dropped here.
    assign beat_s = avmm_data_readdatavalid && (outstanding_r != {LW{1'b0}});

    assign fifo_head_s  = fifo_mem_r[rd_ptr_r];
    assign last_taken_s = out_valid && out_ready && (ser_left_r == 2'd0);
    // Reload when idle, or back-to-back as the last byte of a word leaves.
    assign ser_load_s   = (fifo_level_r != {LW{1'b0}}) && (!out_valid || last_taken_s);

    // Burst size: BURST_LEN, clipped to the words still to request
    always_comb begin
        burst_n_s = 4'(BURST_LEN);
        if (remaining_r < 16'(BURST_LEN)) begin
            burst_n_s = remaining_r[3:0];
        end else begin
            burst_n_s = 4'(BURST_LEN);
        end
    end

    // FSM next-state and single-cycle control strobes
    always_comb begin
        state_next_s = state_r;
        start_acc_s  = 1'b0;
        grant_s      = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    if (word_count != 16'd0) begin
                        state_next_s = S_ARB;
                    end else begin
                        state_next_s = S_FINISH;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ARB: begin
                if (credit_s >= LW'(burst_n_s)) begin
                    grant_s      = 1'b1;
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_ARB;
                end
            end
            S_ISSUE: begin
                if (!avmm_data_waitrequest) begin
                    accept_s = 1'b1;
                    // remaining - n != 0 in the accepting cycle
                    if (remaining_r != 16'(avmm_data_burstcount)) begin
                        state_next_s = S_ARB;
                    end else begin
                        state_next_s = S_DRAIN;
                    end
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if ((outstanding_r == {LW{1'b0}}) && (fifo_level_r == {LW{1'b0}}) && !out_valid) begin
                    state_next_s = S_FINISH;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_FINISH: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Run bookkeeping, busy/done flags and the registered bus command
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r               <= 15'd0;
            remaining_r          <= 16'd0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            avmm_data_addr       <= 15'd0;
            avmm_data_burstcount <= 4'd0;
            avmm_data_read       <= 1'b0;
        end else begin
            done <= (state_r == S_FINISH);

            if (start_acc_s) begin
                busy <= 1'b1;
            end else if (state_r == S_FINISH) begin
                busy <= 1'b0;
            end

            if (start_acc_s) begin
                addr_r      <= start_addr;
                remaining_r <= word_count;
            end else if (accept_s) begin
                // The 15-bit address wraps 0x7FFF -> 0x0000 naturally.
                addr_r      <= addr_r + 15'(avmm_data_burstcount);
                remaining_r <= remaining_r - 16'(avmm_data_burstcount);
            end

            // Command fields stay frozen through waitrequest stalls.
            if (grant_s) begin
                avmm_data_addr       <= addr_r;
                avmm_data_burstcount <= burst_n_s;
                avmm_data_read       <= 1'b1;
            end else if (accept_s) begin
                avmm_data_read       <= 1'b0;
            end
        end
    end

    // Words requested but not yet returned; accept and return may coincide
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_r <= {LW{1'b0}};
        end else if (accept_s) begin
            outstanding_r <= outstanding_r + LW'(avmm_data_burstcount) - LW'(beat_s);
        end else begin
            outstanding_r <= outstanding_r - LW'(beat_s);
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clock) begin
        if (beat_s) begin
            fifo_mem_r[wr_ptr_r] <= avmm_data_readdata;
        end
    end

    // FIFO pointers and fill level; write and read may coincide, even when full
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fifo_level_r <= {LW{1'b0}};
        end else begin
            if (beat_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (ser_load_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            fifo_level_r <= fifo_level_r + LW'(beat_s) - LW'(ser_load_s);
        end
    end

    // Byte serializer: byte 0 goes straight to out_data and the upper three
    // bytes shift down one per accepted transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            ser_shift_r <= 24'd0;
            ser_left_r  <= 2'd0;
        end else if (ser_load_s) begin
            out_valid   <= 1'b1;
            out_data    <= fifo_head_s[7:0];
            ser_shift_r <= fifo_head_s[31:8];
            ser_left_r  <= 2'd3;
        end else if (out_valid && out_ready) begin
            if (ser_left_r != 2'd0) begin
                out_data    <= ser_shift_r[7:0];
                ser_shift_r <= {8'h00, ser_shift_r[23:8]};
                ser_left_r  <= ser_left_r - 2'd1;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ufm_stream_reader.sv
`timescale 1ns/1ps
module tb_ufm_stream_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] start_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [14:0] avmm_data_addr;
    logic        avmm_data_read;
    logic [3:0]  avmm_data_burstcount;
    logic [31:0] avmm_data_readdata;
    logic        avmm_data_waitrequest;
    logic        avmm_data_readdatavalid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    ufm_stream_reader #(.BURST_LEN(8), .FIFO_DEPTH(16)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .start_addr             (start_addr),
        .word_count             (word_count),
        .busy                   (busy),
        .done                   (done),
        .avmm_data_addr         (avmm_data_addr),
        .avmm_data_read         (avmm_data_read),
        .avmm_data_burstcount   (avmm_data_burstcount),
        .avmm_data_readdata     (avmm_data_readdata),
        .avmm_data_waitrequest  (avmm_data_waitrequest),
        .avmm_data_readdatavalid(avmm_data_readdatavalid),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready)
    );

    always #5 clock = ~clock;

    // Flash contents and reference expectations
    logic [31:0] mem [0:32767];
    logic [14:0] exp_b_addr [$];
    logic [3:0]  exp_b_cnt  [$];
    logic [7:0]  exp_bytes  [$];
    logic [31:0] ret_q      [$];

    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  cyc = 0;
    int  wait_cycles = 0;
    int  ready_mode = 0;
    bit  ret_gap = 1'b0;
    bit  hold_returns = 1'b0;
    int  done_cnt = 0;
    int  bytes_acc = 0;
    int  words_req = 0;
    int  read_cycles = 0;
    int  first_beat_cyc = -1;
    int  first_valid_cyc = -1;
    int  job_n = 0;
    int  job_d0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model plus bus / stream monitors
    initial begin : env
        logic        acc_cmd;
        logic        acc_byte;
        bit          prev_stall;
        bit          prev_hold;
        logic [14:0] stall_addr;
        logic [3:0]  stall_bc;
        logic [7:0]  hold_data;
        logic [7:0]  eb;
        int          cmd_age;
        int          loaded;
        avmm_data_waitrequest   = 1'b0;
        avmm_data_readdatavalid = 1'b0;
        avmm_data_readdata      = 32'd0;
        out_ready               = 1'b1;
        cmd_age    = 0;
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
        stall_addr = 15'd0;
        stall_bc   = 4'd0;
        hold_data  = 8'd0;
        forever begin
            @(negedge clock);
            acc_cmd  = avmm_data_read && !avmm_data_waitrequest && !reset;
            acc_byte = out_valid && out_ready && !reset;
            if (reset) begin
                prev_stall = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("cmd_hold_read", 32'(avmm_data_read), 32'd1);
                    check("cmd_hold_addr", 32'(avmm_data_addr), 32'(stall_addr));
                    check("cmd_hold_bc", 32'(avmm_data_burstcount), 32'(stall_bc));
                end
                if (prev_hold) begin
                    check("out_hold_valid", 32'(out_valid), 32'd1);
                    check("out_hold_data", 32'(out_data), 32'(hold_data));
                end
                prev_stall = ((avmm_data_read && avmm_data_waitrequest) === 1'b1);
                stall_addr = avmm_data_addr;
                stall_bc   = avmm_data_burstcount;
                prev_hold  = ((out_valid && !out_ready) === 1'b1);
                hold_data  = out_data;
            end
            if (avmm_data_read === 1'b1 && !reset) read_cycles++;
            if (out_valid === 1'b1 && !reset && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (acc_cmd === 1'b1) begin
                check("burst_pending", 32'(exp_b_addr.size() > 0), 32'd1);
                if (exp_b_addr.size() > 0) begin
                    check("burst_addr", 32'(avmm_data_addr), 32'(exp_b_addr.pop_front()));
                    check("burst_cnt", 32'(avmm_data_burstcount), 32'(exp_b_cnt.pop_front()));
                end
                for (int i = 0; i < int'(avmm_data_burstcount); i++) begin
                    ret_q.push_back(mem[avmm_data_addr + 15'(i)]);
                end
                words_req += int'(avmm_data_burstcount);
                loaded = (bytes_acc + 3) / 4 + ((out_valid === 1'b1 && bytes_acc % 4 == 0) ? 1 : 0);
                check("credit_bound", 32'(words_req <= 16 + loaded), 32'd1);
            end
            if (acc_byte === 1'b1) begin
                bytes_acc++;
                check("byte_pending", 32'(exp_bytes.size() > 0), 32'd1);
                if (exp_bytes.size() > 0) begin
                    eb = exp_bytes.pop_front();
                    check("byte_data", 32'(out_data), 32'(eb));
                end
            end
            if (done === 1'b1 && !reset) begin
                done_cnt++;
                check("done_after_last_byte", 32'(exp_bytes.size()), 32'd0);
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
            @(posedge clock);
            cyc++;
            #1;
            if (acc_cmd === 1'b1) cmd_age = 0;
            if (avmm_data_read === 1'b1) begin
                avmm_data_waitrequest = (cmd_age < wait_cycles);
                cmd_age++;
            end else begin
                avmm_data_waitrequest = 1'b0;
                cmd_age = 0;
            end
            if (!hold_returns && ret_q.size() > 0 && (!ret_gap || $urandom_range(0, 1) == 1)) begin
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata      = ret_q.pop_front();
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
            end else begin
                avmm_data_readdatavalid = 1'b0;
                avmm_data_readdata      = $urandom();
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic pulse_start(input logic [14:0] a, input logic [15:0] n);
        @(posedge clock);
        #1;
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_read"}, 32'(avmm_data_read), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_addr"}, 32'(avmm_data_addr), 32'd0);
        check({tag, "_bc"}, 32'(avmm_data_burstcount), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
    endtask

    // Reference model: burst split and byte order straight from the rules
    task automatic start_job(input logic [14:0] a, input int n, input int w, input int rm, input bit gap);
        int          rem;
        int          k;
        logic [14:0] cur;
        logic [31:0] wd;
        rem = n;
        cur = a;
        while (rem > 0) begin
            k = (rem < 8) ? rem : 8;
            exp_b_addr.push_back(cur);
            exp_b_cnt.push_back(4'(k));
            cur = cur + 15'(k);
            rem -= k;
        end
        for (int i = 0; i < n; i++) begin
            wd = mem[a + 15'(i)];
            for (int b = 0; b < 4; b++) exp_bytes.push_back(wd[8*b +: 8]);
        end
        bytes_acc       = 0;
        words_req       = 0;
        first_beat_cyc  = -1;
        first_valid_cyc = -1;
        job_n           = n;
        job_d0          = done_cnt;
        wait_cycles     = w;
        ready_mode      = rm;
        ret_gap         = gap;
        pulse_start(a, 16'(n));
        @(negedge clock);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_job(input string tag);
        int t;
        t = 0;
        while (done_cnt == job_d0 && t < 20000) begin
            @(posedge clock);
            t++;
        end
        check({tag, "_done_timeout"}, 32'(t < 20000), 32'd1);
        repeat (6) @(posedge clock);
        check({tag, "_done_once"}, 32'(done_cnt - job_d0), 32'd1);
        check({tag, "_bytes_total"}, 32'(bytes_acc), 32'(4 * job_n));
        check({tag, "_bursts_left"}, 32'(exp_b_addr.size()), 32'd0);
        if (job_n > 0) check({tag, "_latency"}, 32'(first_valid_cyc - first_beat_cyc), 32'd2);
        if (t >= 20000) begin
            @(posedge clock);
            #1;
            reset = 1'b1;
            repeat (2) @(posedge clock);
            #1;
            reset = 1'b0;
            exp_bytes.delete();
            exp_b_addr.delete();
            exp_b_cnt.delete();
            ret_q.delete();
            ready_mode = 0;
        end
    endtask

    initial begin : main
        int          t;
        int          rc0;
        logic [14:0] ra;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 15'd0;
        word_count = 16'd0;
        for (int i = 0; i < 32768; i++) mem[i] = $urandom();
        mem[16] = 32'h44332211;
        mem[17] = 32'h88776655;
        mem[18] = 32'hCCBBAA99;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("por");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single short burst with known data
        start_job(15'h0010, 3, 0, 0, 1'b0);
        finish_job("basic3");

        // Three bursts with 3-cycle stalls; a start mid-run must be ignored
        start_job(15'h0123, 20, 3, 0, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("busy_mid_run", 32'(busy), 32'd1);
        pulse_start(15'h1234, 16'd7);
        finish_job("stall20");

        // Downstream stalled: credit gating must stop the reads at 16 words
        start_job(15'h2000, 40, 0, 2, 1'b0);
        repeat (200) @(posedge clock);
        @(negedge clock);
        check("stalled_words_req", 32'(words_req), 32'd16);
        check("stalled_bytes", 32'(bytes_acc), 32'd0);
        check("stalled_valid", 32'(out_valid), 32'd1);
        ready_mode = 0;
        finish_job("backpressure40");

        // Address wrap at the top of flash
        start_job(15'h7FFC, 8, 0, 0, 1'b0);
        finish_job("wrap8");
        start_job(15'h7FFA, 10, 1, 1, 1'b1);
        finish_job("wrap10");

        // Zero-length run, with a start pulse during the busy cycle
        rc0 = read_cycles;
        start_job(15'h0100, 0, 0, 0, 1'b0);
        check("zero_done_early", 32'(done), 32'd0);
        start      = 1'b1;
        start_addr = 15'h0200;
        word_count = 16'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("zero_done_pulse", 32'(done), 32'd1);
        check("zero_busy_clear", 32'(busy), 32'd0);
        finish_job("zero");
        check("zero_no_reads", 32'(read_cycles - rc0), 32'd0);
        check("zero_idle_after", 32'(busy), 32'd0);

        // Reset with 5 words outstanding, then stale return beats
        hold_returns = 1'b1;
        start_job(15'h0400, 5, 0, 0, 1'b0);
        t = 0;
        while (words_req < 5 && t < 100) begin
            @(posedge clock);
            t++;
        end
        check("abort_cmd_accepted", 32'(words_req), 32'd5);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_vals("mid_reset");
        exp_bytes.delete();
        exp_b_addr.delete();
        exp_b_cnt.delete();
        @(posedge clock);
        #1;
        reset        = 1'b0;
        hold_returns = 1'b0;
        t = 0;
        while (ret_q.size() > 0 && t < 100) begin
            @(posedge clock);
            t++;
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("stale_drained", 32'(ret_q.size()), 32'd0);
        check("stale_no_bytes", 32'(bytes_acc), 32'd0);
        check("stale_no_done", 32'(done_cnt - job_d0), 32'd0);
        check("stale_idle", 32'(busy), 32'd0);
        check("stale_no_valid", 32'(out_valid), 32'd0);
        start_job(15'h0555, 1, 0, 0, 1'b0);
        finish_job("after_abort");

        // Randomized runs
        for (int j = 0; j < 6; j++) begin
            ra = 15'($urandom_range(0, 32767));
            start_job(ra, $urandom_range(1, 40), $urandom_range(0, 3), 1, 1'b1);
            finish_job("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
